// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan sequencer.
// Holds the FSM state enum, the channel count and the wrap-around picker function.
package scan_pkg;

    localparam int NCH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DWELL = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] idx;   // chosen channel
        logic       wrap;  // chosen index <= current index
    } pick_t;

    // Next set mask bit strictly after cur, wrapping mod NCH. With cur=NCH-1 this
    // degenerates into a lowest-set-bit search. An empty mask returns cur, no wrap.
    function automatic pick_t next_chan(input logic [NCH-1:0] mask, input logic [1:0] cur);
        pick_t      r;
        logic [1:0] c;
        r.idx  = cur;
        r.wrap = 1'b0;
        // Walk farthest-first so the nearest hit after cur is the final writer.
        for (int k = NCH; k >= 1; k--) begin
            c = cur + 2'(k);
            if (mask[c]) begin
                r.idx  = c;
                r.wrap = (c <= cur);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_next_pick.sv
// Combinational wrap-around priority picker: next enabled channel after cur.
// Shared by the first pick out of IDLE (cur=3) and the end-of-dwell pick.
module scan_next_pick
    import scan_pkg::*;
(
    input  logic [NCH-1:0] mask,
    input  logic [1:0]     cur,
    output logic [1:0]     nxt,
    output logic           wrap
);

    pick_t pick;

    // Pure function of mask and cur; no state.
    always_comb begin
        pick = next_chan(mask, cur);
    end

    assign nxt  = pick.idx;
    assign wrap = pick.wrap;

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a 2-bit channel code through the enabled channels of a
// mask with break-before-make blanking, for driving a 2-to-4 line decoder.
// Optional macro SCAN_FRAME_CNT_EN adds an 8-bit frame counter output.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NCH-1:0]     mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         sel,
    output logic               sel_vld,
    output logic               frame_done,
    output logic               busy
`ifdef SCAN_FRAME_CNT_EN
    ,
    output logic [7:0]         frame_cnt
`endif
);

    localparam int BLANK_W  = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int CNT_W    = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;
    localparam bit NO_BLANK = (BLANK_CYC == 0);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       sel_nxt;
    logic             vld_nxt, fd_nxt, busy_nxt;

    logic [1:0]       pick_cur, pick_idx;
    logic             pick_wrap;
    logic             run_ok;
    logic [CNT_W-1:0] dwell_load, blank_load;
    state_t           entry_state;
    logic [CNT_W-1:0] entry_cnt;
    logic             entry_vld;

    // In IDLE, cur=3 turns the "strictly after" search into a lowest-bit search.
    assign pick_cur = (state == IDLE) ? 2'(NCH - 1) : sel;

    scan_next_pick u_pick (
        .mask (mask),
        .cur  (pick_cur),
        .nxt  (pick_idx),
        .wrap (pick_wrap)
    );

    assign run_ok     = en && (mask != '0);
    // Counters hold "cycles remaining minus one"; dwell=0 behaves as dwell=1.
    assign dwell_load = (dwell == '0) ? '0 : CNT_W'(dwell - 1'b1);
    assign blank_load = CNT_W'(BLANK_CYC - 1);

    // Where a freshly picked channel starts: blanking, or straight into dwell.
    assign entry_state = NO_BLANK ? DWELL : BLANK;
    assign entry_cnt   = NO_BLANK ? dwell_load : blank_load;
    assign entry_vld   = NO_BLANK;

    // Next-state and next-output decode.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        vld_nxt   = sel_vld;
        fd_nxt    = 1'b0;
        busy_nxt  = busy;
        case (state)
            IDLE: begin
                if (run_ok) begin
                    sel_nxt   = pick_idx;
                    busy_nxt  = 1'b1;
                    state_nxt = entry_state;
                    cnt_nxt   = entry_cnt;
                    vld_nxt   = entry_vld;
                end
            end
            BLANK: begin
                if (cnt == '0) begin
                    state_nxt = DWELL;
                    cnt_nxt   = dwell_load;
                    vld_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DWELL: begin
                if (cnt == '0) begin
                    // Last dwell cycle: en/mask are only looked at here.
                    fd_nxt = pick_wrap;
                    if (!run_ok) begin
                        state_nxt = IDLE;
                        vld_nxt   = 1'b0;
                        busy_nxt  = 1'b0;
                    end else begin
                        sel_nxt   = pick_idx;
                        state_nxt = entry_state;
                        cnt_nxt   = entry_cnt;
                        vld_nxt   = entry_vld;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                vld_nxt   = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= '0;
            sel_vld    <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values together.
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sel        <= sel_nxt;
            sel_vld    <= vld_nxt;
            frame_done <= fd_nxt;
            busy       <= busy_nxt;
        end
    end

`ifdef SCAN_FRAME_CNT_EN
    // Frame counter steps in the same cycle frame_done is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 8'd0;
        end else if (fd_nxt) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule
